// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - op encodings and lane packing helper for the SIMD compute unit
package simd_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_SCALE = 2'b10;
    localparam logic [1:0] OP_MAX   = 2'b11;

    // Lane i occupies [i*width +: width] in every packed lane vector.
    function automatic int lane_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/simd_lane.sv
// rtl/simd_lane.sv - combinational ALU for one SIMD lane
module simd_lane
    import simd_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LANE_IDX = 0
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] scalar,
    input  logic [DATA_W-1:0] vec,
    output logic [DATA_W-1:0] result
);

    // Legacy scale mode multiplies the scalar by a fixed per-lane weight.
    localparam logic [DATA_W-1:0] SCALE_K = DATA_W'(2 * (LANE_IDX + 1));

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = vec + scalar;
            OP_MUL:   result = vec * scalar;
            OP_SCALE: result = scalar * SCALE_K;
            OP_MAX:   result = (vec >= scalar) ? vec : scalar;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/simd_compute_unit.sv
// rtl/simd_compute_unit.sv - N-lane SIMD unit, 2-stage valid/ready pipeline with reduction sum
module simd_compute_unit
    import simd_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int SUM_W  = DATA_W + $clog2(LANES),
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [DATA_W-1:0]       in_scalar,
    input  logic [LANES*DATA_W-1:0] in_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_vec,
    output logic [SUM_W-1:0]        out_sum,
    output logic [CNT_W-1:0]        op_count
);

    logic                    advance;
    logic [LANES*DATA_W-1:0] lane_res;
    logic [LANES*DATA_W-1:0] s1_vec;
    logic                    s1_valid;
    logic [SUM_W-1:0]        s1_sum;

    // One bubble-free pipeline: whole chain moves whenever the output slot frees up.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane #(
            .DATA_W   (DATA_W),
            .LANE_IDX (i)
        ) u_lane (
            .op     (in_op),
            .scalar (in_scalar),
            .vec    (in_vec[lane_lsb(i, DATA_W) +: DATA_W]),
            .result (lane_res[lane_lsb(i, DATA_W) +: DATA_W])
        );
    end

    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_sum = s1_sum + SUM_W'(s1_vec[lane_lsb(i, DATA_W) +: DATA_W]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_vec    <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_sum   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_vec    <= lane_res;
            out_valid <= s1_valid;
            out_vec   <= s1_vec;
            out_sum   <= s1_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
